sprite_rom_reader: RTL and testbench

- Avalon-MM read master that fetches a run of 16-bit words from a single-port sprite ROM slave (128 x 16, 7-bit word address, no waitrequest, fixed read latency) and streams them out over a valid/ready interface to the VGA sprite compositor.
- One instance sits in front of each sprite ROM (die faces, pieces).
- Throughput is one word per clock when the consumer is ready. A small credit-controlled FIFO absorbs consumer back-pressure, so the ROM never needs to stall.

---
 rtl/sprite_rd_pkg.sv | 25 ++
 rtl/sprite_rd_fifo.sv | 75 +++++++
 rtl/sprite_rom_reader.sv | 185 ++++++++++++++++++
 tb/tb_sprite_rom_reader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_rd_pkg.sv
`default_nettype none
// ==========================================================================
// sprite_rd_pkg : shared types and widths for the sprite ROM read master
// Revision 1.0
// ==========================================================================
package sprite_rd_pkg;

   localparam int SPR_ADDR_W = 7;
   localparam int SPR_DATA_W = 16;
   localparam int SPR_LEN_W  = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      DRAIN  = 2'd2,
      FINISH = 2'd3
   } state_t;

   typedef struct packed {
      logic valid;
      logic last;
   } ret_tag_t;

endpackage
`default_nettype wire

// File: rtl/sprite_rd_fifo.sv
`default_nettype none
// ==========================================================================
// sprite_rd_fifo : small synchronous FIFO with flush, used as the output buffer
// Revision 1.0
// ==========================================================================
module sprite_rd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 17
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      do_push  = push && (count_q != CW'(DEPTH));
      do_pop   = pop && (count_q != '0);
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;
   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/sprite_rom_reader.sv
`default_nettype none
// ==========================================================================
// sprite_rom_reader : Avalon-MM sprite ROM read master streaming words out
// Revision 1.0
// ==========================================================================
module sprite_rom_reader
   import sprite_rd_pkg::*;
#(
   parameter int ADDR_W       = SPR_ADDR_W,
   parameter int DATA_W       = SPR_DATA_W,
   parameter int LEN_W        = SPR_LEN_W,
   parameter int READ_LATENCY = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [LEN_W-1:0]  start_len,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_chipselect,
   output logic              avm_read,
   output logic [1:0]        avm_byteenable,
   input  logic [DATA_W-1:0] avm_readdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int IW = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, avm_address_q, avm_address_d;
   logic [LEN_W-1:0]  remaining_q, remaining_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic              avm_read_q, avm_read_d, issue_last_q, issue_last_d;
   ret_tag_t          pipe_q [READ_LATENCY];
   ret_tag_t          pipe_d [READ_LATENCY];
   ret_tag_t          tail;
   logic [IW-1:0]     inflight;
   logic              credit_ok;
   logic              fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;
   logic [CW-1:0]     fifo_count;
   logic [DATA_W:0]   fifo_rd_data;

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      remaining_d   = remaining_q;
      avm_address_d = avm_address_q;
      avm_read_d    = 1'b0;
      issue_last_d  = 1'b0;
      fifo_flush    = 1'b0;

      // The registered read strobe is itself in flight until its tag enters the pipe.
      inflight = IW'(avm_read_q);
      for (int i = 0; i < READ_LATENCY; i++) begin
         inflight = inflight + IW'(pipe_q[i].valid);
      end
      credit_ok = (IW'(fifo_count) + inflight + IW'(1)) <= IW'(FIFO_DEPTH);

      tail      = pipe_q[READ_LATENCY-1];
      fifo_push = tail.valid;
      fifo_pop  = out_ready && !fifo_empty;

      pipe_d[0].valid = avm_read_q;
      pipe_d[0].last  = issue_last_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               if (start_len != '0) begin
                  avm_read_d    = 1'b1;
                  avm_address_d = start_addr;
                  addr_d        = start_addr + ADDR_W'(1);
                  remaining_d   = start_len - LEN_W'(1);
                  issue_last_d  = (start_len == LEN_W'(1));
                  state_d       = (start_len == LEN_W'(1)) ? DRAIN : FETCH;
               end else begin
                  state_d = FINISH;
               end
            end
         end
         FETCH: begin
            if (credit_ok) begin
               avm_read_d    = 1'b1;
               avm_address_d = addr_q;
               addr_d        = addr_q + ADDR_W'(1);
               remaining_d   = remaining_q - LEN_W'(1);
               if (remaining_q == LEN_W'(1)) begin
                  issue_last_d = 1'b1;
                  state_d      = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Leave as the final word is being popped so done trails it by one cycle.
            if (inflight == '0 && (fifo_empty || (fifo_count == CW'(1) && fifo_pop))) begin
               state_d = FINISH;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (abort && (state_q == FETCH || state_q == DRAIN)) begin
         state_d      = FINISH;
         avm_read_d   = 1'b0;
         issue_last_d = 1'b0;
         fifo_flush   = 1'b1;
         fifo_push    = 1'b0;
         fifo_pop     = 1'b0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_d[i] = '0;
         end
      end

      busy_d = (state_d == FETCH) || (state_d == DRAIN);
      done_d = (state_d == FINISH);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         remaining_q   <= '0;
         avm_address_q <= '0;
         avm_read_q    <= 1'b0;
         issue_last_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         remaining_q   <= remaining_d;
         avm_address_q <= avm_address_d;
         avm_read_q    <= avm_read_d;
         issue_last_q  <= issue_last_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         pipe_q        <= pipe_d;
      end
   end

   sprite_rd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W + 1)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .flush   (fifo_flush),
      .wr_data ({tail.last, avm_readdata}),
      .rd_data (fifo_rd_data),
      .count   (fifo_count),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(fifo_push && fifo_full));

   assign busy           = busy_q;
   assign done           = done_q;
   assign avm_address    = avm_address_q;
   assign avm_read       = avm_read_q;
   assign avm_chipselect = avm_read_q;
   assign avm_byteenable = 2'b11;
   assign out_data       = fifo_rd_data[DATA_W-1:0];
   assign out_valid      = !fifo_empty;
   assign out_last       = fifo_rd_data[DATA_W] && !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_reader.sv
`default_nettype none
// ==========================================================================
// tb_sprite_rom_reader : directed self-checking bench for sprite_rom_reader
// Revision 1.0
// ==========================================================================
module tb_sprite_rom_reader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start, abort, out_ready;
   logic [6:0]  start_addr;
   logic [7:0]  start_len;
   logic        busy, done, avm_chipselect, avm_read, out_valid, out_last;
   logic [6:0]  avm_address;
   logic [1:0]  avm_byteenable;
   logic [15:0] avm_readdata, out_data, rom_q;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int start_cyc, abort_cyc;
   int first_valid_cyc, last_valid_cyc, last_read_cyc, done_cyc, done_count;
   bit busy_seen, prev_stall;
   logic [15:0] prev_data;
   logic [6:0]  rd_q [$];
   logic [16:0] out_q [$];

   sprite_rom_reader dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .start_addr     (start_addr),
      .start_len      (start_len),
      .abort          (abort),
      .busy           (busy),
      .done           (done),
      .avm_address    (avm_address),
      .avm_chipselect (avm_chipselect),
      .avm_read       (avm_read),
      .avm_byteenable (avm_byteenable),
      .avm_readdata   (avm_readdata),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_last       (out_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ROM word i holds 0xA000 + i, returned one cycle after the read
   always @(posedge clk) if (avm_read) rom_q <= 16'hA000 + {9'd0, avm_address};
   assign avm_readdata = rom_q;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (avm_read) begin
         rd_q.push_back(avm_address);
         last_read_cyc = cyc;
         check_eq("chipsel_be", {29'd0, avm_chipselect, avm_byteenable}, 32'h7);
      end
      if (prev_stall && out_valid) check_eq("hold_stable", {16'd0, out_data}, {16'd0, prev_data});
      if (out_valid) begin
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
         last_valid_cyc = cyc;
         if (out_ready) out_q.push_back({out_last, out_data});
      end
      if (done) begin
         done_count++;
         if (done_cyc < 0) done_cyc = cyc;
      end
      if (busy) busy_seen = 1'b1;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
   end

   task automatic clear_log();
      rd_q.delete();
      out_q.delete();
      first_valid_cyc = -1;
      last_valid_cyc  = -1;
      last_read_cyc   = -1;
      done_cyc        = -1;
      done_count      = 0;
      busy_seen       = 1'b0;
   endtask

   task automatic do_start(input logic [6:0] a, input logic [7:0] l);
      @(posedge clk); #1;
      start = 1'b1; start_addr = a; start_len = l;
      @(posedge clk); #1;
      start = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic wait_done(input int max_cyc);
      int n = 0;
      while (done_count == 0 && n < max_cyc) begin
         @(negedge clk); #1;
         n++;
      end
      if (done_count == 0) check_eq("done_timeout", 32'd0, 32'd1);
      repeat (2) @(negedge clk);
      #1;
   endtask

   task automatic check_stream(input string pfx, input logic [6:0] a0, input int len);
      logic [6:0] a;
      check_eq({pfx, "_nreads"}, 32'(rd_q.size()), 32'(len));
      check_eq({pfx, "_nwords"}, 32'(out_q.size()), 32'(len));
      for (int i = 0; i < len; i++) begin
         a = a0 + 7'(i);
         if (i < rd_q.size()) check_eq({pfx, "_addr"}, {25'd0, rd_q[i]}, {25'd0, a});
         if (i < out_q.size())
            check_eq({pfx, "_word"}, {15'd0, out_q[i]}, {15'd0, (i == len - 1), 16'hA000 + {9'd0, a}});
      end
   endtask

   task automatic run_basic(input string pfx);
      clear_log();
      out_ready = 1'b1;
      do_start(7'h10, 8'd4);
      wait_done(40);
      check_stream(pfx, 7'h10, 4);
      check_eq({pfx, "_first_valid"}, 32'(first_valid_cyc - start_cyc), 32'd2);
      check_eq({pfx, "_done_cyc"}, 32'(done_cyc - start_cyc), 32'd6);
      check_eq({pfx, "_done_cnt"}, 32'(done_count), 32'd1);
      check_eq({pfx, "_busy_end"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      start_addr = '0; start_len = '0;
      clear_log();
      prev_stall = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_ctl", {26'd0, busy, done, avm_read, avm_chipselect, out_valid, out_last}, 32'd0);
      check_eq("reset_addr", {25'd0, avm_address}, 32'd0);
      reset_n = 1'b1;

      // Basic run
      run_basic("basic");

      // Address wrap 127 -> 0
      clear_log();
      do_start(7'h7E, 8'd4);
      wait_done(40);
      check_stream("wrap", 7'h7E, 4);

      // Back-pressure: only the FIFO depth worth of reads may be issued
      clear_log();
      out_ready = 1'b0;
      do_start(7'h20, 8'd8);
      repeat (10) @(posedge clk);
      #1;
      check_eq("stall_nreads", 32'(rd_q.size()), 32'd4);
      check_eq("stall_nwords", 32'(out_q.size()), 32'd0);
      check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      wait_done(60);
      check_stream("stall", 7'h20, 8);

      // Abort two cycles after start
      clear_log();
      do_start(7'h30, 8'd16);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      abort_cyc = cyc;
      repeat (4) @(posedge clk);
      #1;
      check_eq("abort_done_cyc", 32'(done_cyc), 32'(abort_cyc));
      check_eq("abort_done_cnt", 32'(done_count), 32'd1);
      check_eq("abort_busy", {31'd0, busy}, 32'd0);
      check_eq("abort_no_valid", {31'd0, last_valid_cyc >= abort_cyc}, 32'd0);
      check_eq("abort_no_read", {31'd0, last_read_cyc >= abort_cyc}, 32'd0);
      clear_log();
      do_start(7'h50, 8'd2);
      wait_done(40);
      check_stream("post_abort", 7'h50, 2);

      // Empty run
      clear_log();
      do_start(7'h05, 8'd0);
      repeat (3) @(negedge clk);
      #1;
      check_eq("len0_nreads", 32'(rd_q.size()), 32'd0);
      check_eq("len0_done_cyc", 32'(done_cyc - start_cyc), 32'd0);
      check_eq("len0_done_cnt", 32'(done_count), 32'd1);
      check_eq("len0_busy", {31'd0, busy_seen}, 32'd0);

      // Start while busy is ignored
      clear_log();
      do_start(7'h60, 8'd4);
      start = 1'b1; start_addr = 7'h00; start_len = 8'd8;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(40);
      check_stream("busy_start", 7'h60, 4);
      check_eq("busy_start_done", 32'(done_count), 32'd1);

      // Asynchronous reset mid-run
      clear_log();
      do_start(7'h10, 8'd8);
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("arst_ctl", {26'd0, busy, done, avm_read, avm_chipselect, out_valid, out_last}, 32'd0);
      check_eq("arst_addr", {25'd0, avm_address}, 32'd0);
      check_eq("arst_data", {16'd0, out_data}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      run_basic("rerun");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
